// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding request controller for an 8-bit synchronous memory array.
// Define MEMCTRL_WR_VERIFY_EN to add a read-back verify phase after every write.
module mem_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned RD_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [7:0]        REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [7:0]        RSP_RDATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  inout  wire  [7:0]        MEM_DATA,
  output logic              MEM_LOAD,
  output logic              MEM_WRITE,
  output logic              MEM_OE
);

  // A wait of 0 is treated as 1 so the counter always starts from a sane value.
  localparam int unsigned RdWaitEff = (RD_WAIT == 0) ? 1 : RD_WAIT;
  localparam logic [3:0]  CntInit   = 4'(RdWaitEff - 1);

`ifdef MEMCTRL_WR_VERIFY_EN
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StRead, StVerify, StResp} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StRead, StResp} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          rdata_q, rdata_d;
`ifdef MEMCTRL_WR_VERIFY_EN
  logic                err_q, err_d;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef MEMCTRL_WR_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef MEMCTRL_WR_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef MEMCTRL_WR_VERIFY_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR;
          wr_d    = REQ_WR;
          wdata_d = REQ_WDATA;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = CntInit;
        state_d = wr_q ? StWrite : StRead;
      end
      StWrite: begin
`ifdef MEMCTRL_WR_VERIFY_EN
        cnt_d   = CntInit;
        state_d = StVerify;
`else
        state_d = StResp;
`endif
      end
      StRead: begin
        if (cnt_q == '0) begin
          rdata_d = MEM_DATA;
`ifdef MEMCTRL_WR_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef MEMCTRL_WR_VERIFY_EN
      StVerify: begin
        if (cnt_q == '0) begin
          rdata_d = MEM_DATA;
          err_d   = (MEM_DATA != wdata_q);
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      StResp: begin
        if (RSP_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready is gated by the reset pin so it stays low for the whole reset assertion.
  assign REQ_READY   = RST_N && (state_q == StIdle);
  assign RSP_VALID   = (state_q == StResp);
  assign RSP_RDATA   = rdata_q;
`ifdef MEMCTRL_WR_VERIFY_EN
  assign RSP_ERR     = err_q;
  assign MEM_OE      = (state_q == StRead) || (state_q == StVerify);
`else
  assign RSP_ERR     = 1'b0;
  assign MEM_OE      = (state_q == StRead);
`endif
  assign MEM_ADDRESS = addr_q;
  assign MEM_LOAD    = (state_q == StLoad);
  assign MEM_WRITE   = (state_q == StWrite);
  assign MEM_DATA    = MEM_WRITE ? wdata_q : 8'bz;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: two instances (RD_WAIT=1 and RD_WAIT=4), each with a
// behavioural memory array and a response scoreboard.
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int unsigned RW = (k == 0) ? 1 : 4;

    logic          rst_n, req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
    logic          mem_load, mem_write, mem_oe;
    logic [AW-1:0] req_addr, mem_address, la;
    logic [7:0]    req_wdata, rsp_rdata, mem_dout;
    wire  [7:0]    mem_data;
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          drive_force;
    logic [7:0]    force_val;
    logic [8:0]    sb_q [$];
    logic [8:0]    sb_e;
    logic [7:0]    shadow [int];
    logic [7:0]    model_rdata;

    mem_ctrl #(.ADDR_W(AW), .RD_WAIT(RW)) u_dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .REQ_VALID  (req_valid),
      .REQ_READY  (req_ready),
      .REQ_WR     (req_wr),
      .REQ_ADDR   (req_addr),
      .REQ_WDATA  (req_wdata),
      .RSP_VALID  (rsp_valid),
      .RSP_READY  (rsp_ready),
      .RSP_RDATA  (rsp_rdata),
      .RSP_ERR    (rsp_err),
      .MEM_ADDRESS(mem_address),
      .MEM_DATA   (mem_data),
      .MEM_LOAD   (mem_load),
      .MEM_WRITE  (mem_write),
      .MEM_OE     (mem_oe)
    );

    // Memory array: load latches the address, write stores, OE drives the bus.
    always @(posedge clk) begin
      if (mem_load)  la <= mem_address;
      if (mem_write) mem[la] <= mem_data;
    end
    assign mem_dout = drive_force ? force_val : mem[la];
    assign mem_data = mem_oe ? mem_dout : 8'bz;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      check($sformatf("rw%0d_%s", RW, name), obs, exp);
    endtask

    always @(negedge clk) begin
      if (rst_n) begin
        chk("wr_oe_excl", {31'b0, mem_write & mem_oe}, 32'd0);
        if (mem_oe) chk("bus_read_clean", {24'b0, mem_data}, {24'b0, mem_dout});
        if (rsp_valid && rsp_ready) begin
          chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
          if (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, sb_e[7:0]});
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb_e[8]});
          end
        end
      end
    end

    task automatic wait_accept();
      int t;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("accept_in_time", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
    endtask

    task automatic xact(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wd,
                        input int stall);
      int t, lat, ld_n, wr_n, oe_n, exp_lat, exp_oe;
      logic [7:0] exp_rd;
      logic       exp_err;
      exp_err = 1'b0;
      if (wr) begin
`ifdef MEMCTRL_WR_VERIFY_EN
        exp_rd  = drive_force ? force_val : wd;
        exp_err = drive_force ? (force_val != wd) : 1'b0;
        exp_lat = 3 + RW;
        exp_oe  = RW;
`else
        exp_rd  = model_rdata;
        exp_lat = 3;
        exp_oe  = 0;
`endif
        shadow[int'(addr)] = wd;
      end else begin
        exp_rd  = shadow[int'(addr)];
        exp_lat = 2 + RW;
        exp_oe  = RW;
      end
      model_rdata = exp_rd;
      sb_q.push_back({exp_err, exp_rd});

      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      rsp_ready = 1'b0;
      wait_accept();
      // Latency counts the accept cycle itself.
      lat = 1; ld_n = 0; wr_n = 0; oe_n = 0; t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 40) begin
        ld_n += int'(mem_load);
        wr_n += int'(mem_write);
        oe_n += int'(mem_oe);
        if (mem_write) chk("mem_wdata", {24'b0, mem_data}, {24'b0, wd});
        chk("mem_addr", mem_address, addr);
        chk("busy_not_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        lat++;
        t++;
      end
      chk("rsp_in_time", {31'b0, rsp_valid}, 32'd1);
      chk("latency", lat, exp_lat);
      chk("load_pulses", ld_n, 1);
      chk("write_pulses", wr_n, wr ? 1 : 0);
      chk("oe_cycles", oe_n, exp_oe);
      for (int i = 0; i < stall; i++) begin
        chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("hold_rdata", {24'b0, rsp_rdata}, {24'b0, exp_rd});
        chk("hold_not_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
      end
      chk("resp_addr", mem_address, addr);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("idle_addr_kept", mem_address, addr);
      rsp_ready = 1'b0;
    endtask

    task automatic reset_mid_read();
      int t;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 20'h00003;
      wait_accept();
      t = 0;
      @(negedge clk);
      while (!mem_oe && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk("rst_in_read", {31'b0, mem_oe}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_oe", {31'b0, mem_oe}, 32'd0);
      chk("rst_load", {31'b0, mem_load}, 32'd0);
      chk("rst_write", {31'b0, mem_write}, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rdata", {24'b0, rsp_rdata}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", {31'b0, req_ready}, 32'd1);
      chk("rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      model_rdata = 8'h00;
    endtask

    initial begin
      logic [AW-1:0] ra;
      logic [7:0]    rd;
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_wr      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      rsp_ready   = 1'b0;
      drive_force = 1'b0;
      force_val   = '0;
      model_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("por_ready", {31'b0, req_ready}, 32'd0);
      chk("por_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("por_strobes", {29'b0, mem_load, mem_write, mem_oe}, 32'd0);
      chk("por_rdata", {24'b0, rsp_rdata}, 32'd0);
      chk("por_err", {31'b0, rsp_err}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("por_rel_ready", {31'b0, req_ready}, 32'd1);

      reset_mid_read();
      xact(1'b1, 20'h0ABCD, 8'h5A, 0);
      xact(1'b0, 20'h0ABCD, 8'h00, 0);
      xact(1'b1, 20'hFFFFF, 8'hA5, 0);
      xact(1'b1, 20'h00000, 8'h3C, 0);
      xact(1'b0, 20'hFFFFF, 8'h00, 0);
      xact(1'b0, 20'h00000, 8'h00, 0);
      xact(1'b1, 20'h00010, 8'h77, 0);
      xact(1'b0, 20'h00010, 8'h00, 5);
      xact(1'b1, 20'h00003, 8'hC3, 0);
      xact(1'b0, 20'h00003, 8'h00, 0);
      for (int i = 0; i < 4; i++) begin
        ra = AW'($urandom);
        rd = 8'($urandom);
        xact(1'b1, ra, rd, 0);
        xact(1'b0, ra, 8'h00, i);
      end
`ifdef MEMCTRL_WR_VERIFY_EN
      xact(1'b1, 20'h00020, 8'h11, 0);
      drive_force = 1'b1;
      force_val   = 8'h10;
      xact(1'b1, 20'h00020, 8'h11, 0);
      drive_force = 1'b0;
`endif
      chk("sb_drained", sb_q.size(), 32'd0);
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 50000 && n_done < 2; i++) @(posedge clk);
    check("run_complete", n_done, 32'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
